// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for serial_adder.
//   master : drives START/SUB/CIN/A/B, observes BUSY/DONE/SUM/COUT/OVF
//   slave  : the adder side of the same signals
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic             SUB;
    logic             CIN;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             OVF;

    modport master (
        output START, SUB, CIN, A, B,
        input  BUSY, DONE, SUM, COUT, OVF
    );

    modport slave (
        input  START, SUB, CIN, A, B,
        output BUSY, DONE, SUM, COUT, OVF
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract, DIGIT bits per clock, LSB first.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus.START  : capture operands and begin (honoured in IDLE or DONE)
//   bus.SUB    : 0 = A+B+CIN, 1 = A-B
//   bus.CIN    : carry-in, add mode only
//   bus.A/B    : operands
//   bus.BUSY   : operation in progress
//   bus.DONE   : one-cycle result-valid pulse
//   bus.SUM/COUT/OVF : registered result, updated only when entering DONE
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Ripple slice over the low DIGIT bits of the shifting operands.
    // c[DIGIT-1] is the carry into the slice MSB, which on the final slice
    // is the carry into the word MSB and feeds the overflow flag.
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] slice;
    logic [WIDTH-1:0] slice_ext;

    always_comb begin
        c         = '0;
        slice     = '0;
        slice_ext = '0;
        c[0]      = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            slice[i] = a_q[i] ^ b_q[i] ^ c[i];
            c[i+1]   = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
        end
        slice_ext[DIGIT-1:0] = slice;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.START) begin
                    state_d = S_RUN;
                    a_d     = bus.A;
                    // subtraction is A + ~B + 1
                    b_d     = bus.SUB ? ~bus.B : bus.B;
                    carry_d = bus.SUB ? 1'b1 : bus.CIN;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = c[DIGIT];
                // result slices enter at the top and walk down to bit 0
                acc_d   = (acc_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                    sum_d   = acc_d;
                    cout_d  = c[DIGIT];
                    ovf_d   = c[DIGIT] ^ c[DIGIT-1];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.BUSY = (state_q == S_RUN);
    assign bus.DONE = (state_q == S_DONE);
    assign bus.SUM  = sum_q;
    assign bus.COUT = cout_q;
    assign bus.OVF  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors against three serial_adder builds
// (8/1, 8/4, 16/4). One build is selected at a time; the others idle.
module tb_serial_adder;
    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic        start, sub, cin;
    logic [15:0] a, b;
    logic        o_busy, o_done, o_cout, o_ovf;
    logic [15:0] o_sum;
    int          n_chk, n_err;

    serial_adder_if #(.WIDTH(8))  if8  ();
    serial_adder_if #(.WIDTH(8))  if84 ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(8),  .DIGIT(1)) u_dut8  (.CLK(clk), .RST_N(rst_n), .bus(if8));
    serial_adder #(.WIDTH(8),  .DIGIT(4)) u_dut84 (.CLK(clk), .RST_N(rst_n), .bus(if84));
    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (.CLK(clk), .RST_N(rst_n), .bus(if16));

    assign if8.START  = start && (sel == 2'd0);
    assign if84.START = start && (sel == 2'd1);
    assign if16.START = start && (sel == 2'd2);
    assign if8.SUB  = sub;  assign if84.SUB  = sub;  assign if16.SUB  = sub;
    assign if8.CIN  = cin;  assign if84.CIN  = cin;  assign if16.CIN  = cin;
    assign if8.A    = a[7:0]; assign if84.A = a[7:0]; assign if16.A = a;
    assign if8.B    = b[7:0]; assign if84.B = b[7:0]; assign if16.B = b;

    always_comb begin
        o_busy = if8.BUSY; o_done = if8.DONE; o_cout = if8.COUT; o_ovf = if8.OVF;
        o_sum  = {8'h00, if8.SUM};
        if (sel == 2'd1) begin
            o_busy = if84.BUSY; o_done = if84.DONE; o_cout = if84.COUT; o_ovf = if84.OVF;
            o_sum  = {8'h00, if84.SUM};
        end else if (sel == 2'd2) begin
            o_busy = if16.BUSY; o_done = if16.DONE; o_cout = if16.COUT; o_ovf = if16.OVF;
            o_sum  = if16.SUM;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Issue one operation on the selected build; returns at the negedge of
    // the DONE cycle. b2b=1 means the caller is already in a DONE cycle and
    // the start is presented there. hold_en checks SUM stays at hold during RUN.
    task automatic run_op(input string tag, input int n, input logic [15:0] ai, bi,
                          input logic si, ci, input logic [15:0] es, input logic ec, eo,
                          input logic b2b, input logic hold_en, input logic [15:0] hold);
        int bad_busy, bad_hold;
        if (!b2b) @(negedge clk);
        a = ai; b = bi; sub = si; cin = ci; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bad_busy = 0; bad_hold = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if ({o_busy, o_done} !== 2'b10) bad_busy++;
            if (hold_en && o_sum !== hold) bad_hold++;
        end
        chk({tag, "_busy"}, bad_busy, 0);
        if (hold_en) chk({tag, "_hold"}, bad_hold, 0);
        @(negedge clk);
        chk({tag, "_done"}, {o_busy, o_done}, 2'b01);
        chk({tag, "_sum"},  o_sum, es);
        chk({tag, "_cout"}, o_cout, ec);
        chk({tag, "_ovf"},  o_ovf, eo);
    endtask

    initial begin
        int bad, dcnt;
        n_chk = 0; n_err = 0;
        sel = 2'd0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset8",  {if8.BUSY, if8.DONE, if8.COUT, if8.OVF, if8.SUM}, 0);
        chk("reset16", {if16.BUSY, if16.DONE, if16.COUT, if16.OVF, if16.SUM}, 0);
        rst_n = 1'b1;

        // latency, SUM held at 0 during RUN, single-cycle DONE
        run_op("add0f01", 8, 16'h0F, 16'h01, 0, 0, 16'h10, 0, 0, 0, 1, 16'h00);
        @(negedge clk);
        chk("add0f01_after", {o_busy, o_done}, 2'b00);
        chk("add0f01_keep", o_sum, 16'h10);

        run_op("add7f01",  8, 16'h7F, 16'h01, 0, 0, 16'h80, 0, 1, 0, 1, 16'h10);
        run_op("addffcin", 8, 16'hFF, 16'h00, 0, 1, 16'h00, 1, 0, 0, 0, 16'h0);
        run_op("sub0507",  8, 16'h05, 16'h07, 1, 1, 16'hFE, 0, 0, 0, 0, 16'h0);
        run_op("sub8001",  8, 16'h80, 16'h01, 1, 0, 16'h7F, 1, 1, 0, 0, 16'h0);
        run_op("subb0",    8, 16'h3A, 16'h00, 1, 0, 16'h3A, 1, 0, 0, 0, 16'h0);

        // back-to-back: start presented in the DONE cycle
        run_op("b2b_1", 8, 16'h20, 16'h22, 0, 0, 16'h42, 0, 0, 0, 0, 16'h0);
        run_op("b2b_2", 8, 16'hC8, 16'h64, 0, 0, 16'h2C, 1, 0, 1, 1, 16'h42);
        @(negedge clk);
        chk("b2b_after", {o_busy, o_done}, 2'b00);

        // START during RUN with other operands is ignored
        @(negedge clk);
        a = 16'h12; b = 16'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 3) begin a = 16'hFF; b = 16'hFF; sub = 1'b1; start = 1'b1; end
            else start = 1'b0;
            if ({o_busy, o_done} !== 2'b10) bad++;
        end
        start = 1'b0;
        chk("ign_busy", bad, 0);
        @(negedge clk);
        chk("ign_done", {o_busy, o_done}, 2'b01);
        chk("ign_sum", {o_cout, o_ovf, o_sum}, {2'b00, 16'h46});
        @(negedge clk);
        chk("ign_nodone", {o_busy, o_done}, 2'b00);

        // reset in cycle 4 of an add
        @(negedge clk);
        a = 16'h33; b = 16'h11; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst_mid", {o_busy, o_done, o_cout, o_ovf, o_sum}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_done || o_busy) dcnt++;
        end
        chk("rst_quiet", dcnt, 0);
        run_op("post_rst", 8, 16'h55, 16'h2A, 0, 0, 16'h7F, 0, 0, 0, 1, 16'h00);

        // DIGIT = 4 builds
        sel = 2'd1;
        run_op("d4_9c64", 2, 16'h9C, 16'h64, 0, 0, 16'h00, 1, 0, 0, 0, 16'h0);
        run_op("d4_sub",  2, 16'h80, 16'h01, 1, 0, 16'h7F, 1, 1, 0, 0, 16'h0);
        run_op("d4_ovf",  2, 16'h70, 16'h10, 0, 0, 16'h80, 0, 1, 0, 0, 16'h0);
        sel = 2'd2;
        run_op("w16_ffff", 4, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000);
        run_op("w16_add",  4, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0, 0, 16'h0);
        @(negedge clk);
        chk("w16_after", {o_busy, o_done}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the board-level ripple adder.
- Captures two WIDTH-bit operands on a start strobe and adds or subtracts them DIGIT bits per clock, LSB first, through a DIGIT-bit ripple slice.
- Presents a registered sum, carry-out and signed overflow with a one-cycle DONE pulse.
- Sits between switch/register sources and LED/display sinks, trading latency for a small adder slice.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 2.
- DIGIT, 1, bits processed per clock; must divide WIDTH exactly.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  operation request; sampled only in IDLE or DONE state.
- SUB  input  1  mode: 0 = A+B+CIN, 1 = A-B (CIN ignored); captured with START.
- CIN  input  1  carry-in for add mode; captured with START.
- A  input  WIDTH  first operand; captured with START.
- B  input  WIDTH  second operand; captured with START.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse: result valid.
- SUM  output  WIDTH  result, registered and held.
- COUT  output  1  carry-out of the MSB; in SUB mode 1 = no borrow.
- OVF  output  1  two's-complement signed overflow.

Behaviour:
- Reset: RST_N low asynchronously forces state IDLE and clears BUSY, DONE, SUM, COUT, OVF and all internal operand, carry and counter registers to 0. This applies at any time, including mid-operation; the in-flight result is discarded.
- N = WIDTH/DIGIT.
- State machine: IDLE, RUN, DONE.
  - IDLE: START=1 at an edge -> RUN. Same edge captures A; captures B (SUB=0) or ~B (SUB=1); sets carry = CIN (SUB=0) or 1 (SUB=1); clears digit counter.
  - RUN: each edge adds the current DIGIT-bit slice of both operands plus carry, stores the slice result, updates carry and increments the counter. After the N-th RUN edge -> DONE.
  - DONE: DONE=1 for exactly this one cycle. SUM, COUT and OVF update on the edge entering DONE.
    - START=1 in this cycle -> RUN with a new capture (back-to-back operation; DONE still pulses this cycle).
    - Otherwise -> IDLE.
- Latency: START sampled at edge 0 -> BUSY=1 for cycles 1..N -> DONE=1 in cycle N+1. Throughput is one result per N+1 cycles.
- BUSY = (state == RUN). BUSY and DONE are never high together.
- START in RUN is ignored; no queuing. A, B, SUB and CIN changes during RUN have no effect.
- SUM, COUT and OVF hold their last values outside the DONE-entry edge; no intermediate slices are visible on SUM.
- Arithmetic: SUM = low WIDTH bits of the full result; COUT = bit WIDTH.
- OVF = carry into MSB XOR carry out of MSB, computed on the effective operands (B or ~B).
  - With DIGIT>1, the carry into the MSB is derived inside the final slice.
- SUB=1, B=0: COUT=1, OVF=0, SUM=A.
- Parameter violations (WIDTH mod DIGIT ≠ 0) are rejected at elaboration.

Test Plan:
- WIDTH=8, DIGIT=1, SUB=0, CIN=0: A=8'h0F, B=8'h01, START at edge 0 -> BUSY in cycles 1-8, DONE only in cycle 9, SUM=8'h10, COUT=0, OVF=0; SUM remains 8'h00 through cycles 1-8.
- Add boundaries, DIGIT=1:
  - A=8'h7F, B=8'h01 -> SUM=8'h80, COUT=0, OVF=1.
  - A=8'hFF, B=8'h00, CIN=1 -> SUM=8'h00, COUT=1, OVF=0.
- Subtract, DIGIT=1:
  - A=8'h05, B=8'h07, SUB=1, CIN=1 (ignored) -> SUM=8'hFE, COUT=0, OVF=0.
  - A=8'h80, B=8'h01, SUB=1 -> SUM=8'h7F, COUT=1, OVF=1.
- WIDTH=8, DIGIT=4: A=8'h9C, B=8'h64 -> BUSY cycles 1-2, DONE cycle 3, SUM=8'h00, COUT=1, OVF=0.
  - Repeat with WIDTH=16, DIGIT=4: A=16'hFFFF, B=16'h0001 -> DONE in cycle 5, SUM=16'h0000, COUT=1.
- START during RUN with different operands -> ignored; original result returned. START asserted in the DONE cycle -> new BUSY next cycle, second DONE exactly N+1 cycles after it, SUM/COUT/OVF correct for the second operand pair.
- Reset mid-operation: RST_N low in cycle 4 of a DIGIT=1 add -> BUSY, DONE, SUM, COUT, OVF = 0 immediately (asynchronous). No DONE follows after release. Next START produces a correct result.
